// File: rtl/pipe_mem_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM states, MEM/WB record and bubble value.
package pipe_mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int RN_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [DATA_W-1:0] mo;
        logic [DATA_W-1:0] alu;
        logic [RN_W-1:0]   rn;
    } memwb_t;

    localparam logic            MEMWB_BUBBLE_WREG  = 1'b0;
    localparam logic            MEMWB_BUBBLE_M2REG = 1'b0;
    localparam logic [RN_W-1:0] MEMWB_BUBBLE_RN    = 5'd0;

    localparam memwb_t MEMWB_RESET = '{
        wreg:  1'b0,
        m2reg: 1'b0,
        mo:    32'd0,
        alu:   32'd0,
        rn:    5'd0
    };

    // A bubble kills the control fields but keeps the data fields, so they hold.
    function automatic memwb_t memwb_bubble(input memwb_t cur);
        memwb_t b;
        b       = cur;
        b.wreg  = MEMWB_BUBBLE_WREG;
        b.m2reg = MEMWB_BUBBLE_M2REG;
        b.rn    = MEMWB_BUBBLE_RN;
        return b;
    endfunction

endpackage

// File: rtl/pipe_mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface pipe_mem_stage_if
    import pipe_mem_stage_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ack
    );
endinterface

// File: rtl/pipe_mem_stage_mwreg.sv
// MEM/WB pipeline register: async active-low clear, otherwise loads the next record or a bubble.
module pipe_mem_stage_mwreg
    import pipe_mem_stage_pkg::*;
(
    input  logic   clock,
    input  logic   resetn,
    input  logic   bubble,
    input  memwb_t d,
    output memwb_t q
);

    // MEM/WB register with bubble insertion
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q <= MEMWB_RESET;
        end else if (bubble) begin
            q <= memwb_bubble(q);
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: data-memory access over a req/ack bus, stall generation and MEM/WB load.
// Optional access timeout with sticky mem_err is built when PIPE_MEM_TIMEOUT_EN is defined.
module pipe_mem_stage
    import pipe_mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic [DATA_W-1:0] mAlu,
    input  logic [DATA_W-1:0] mB,
    input  logic [RN_W-1:0]   mrn,
    pipe_mem_stage_if.master  dm,
    output logic              mem_stall,
    output logic              mem_err,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [DATA_W-1:0] wmo,
    output logic [DATA_W-1:0] walu,
    output logic [RN_W-1:0]   wrn
);

    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("pipe_mem_stage: TIMEOUT must be in 2..255");
    end

    mem_state_t state_r;
    logic       acc_s;
    logic       stall_s;
    logic       bubble_s;
    logic       timeout_s;
    memwb_t     memwb_d_s;
    memwb_t     memwb_q_s;

    // Request is suppressed during reset and in the error-recovery cycle.
    assign acc_s    = resetn & (mm2reg | mwmem) & (state_r != ERR);
    assign stall_s  = acc_s & ~dm.dm_ack;
    assign bubble_s = stall_s | (state_r == ERR);

    assign dm.dm_req   = acc_s;
    assign dm.dm_we    = mwmem;
    assign dm.dm_addr  = mAlu[ADDR_W+1:2];
    assign dm.dm_wdata = mB;
    assign mem_stall   = stall_s;

`ifdef PIPE_MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt_r;
    logic       err_r;

    // wait_cnt_r counts stalled cycles of the current access, including the first.
    assign timeout_s = (state_r == WAIT) & ~dm.dm_ack & (wait_cnt_r == TO_LAST_C);
    assign mem_err   = err_r;

    // Wait counter and sticky timeout flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_r <= 8'd0;
            err_r      <= 1'b0;
        end else begin
            if (stall_s && !timeout_s) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= 8'd0;
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end
`else
    assign timeout_s = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // Access FSM
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (stall_s) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (dm.dm_ack) begin
                        state_r <= IDLE;
                    end else if (timeout_s) begin
                        state_r <= ERR;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                ERR:     state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Next MEM/WB record; a simultaneous load+store is treated as a store.
    always_comb begin
        memwb_d_s       = MEMWB_RESET;
        memwb_d_s.wreg  = mwreg;
        memwb_d_s.m2reg = mm2reg & ~mwmem;
        memwb_d_s.alu   = mAlu;
        memwb_d_s.rn    = mrn;
        if (dm.dm_ack && !mwmem) begin
            memwb_d_s.mo = dm.dm_rdata;
        end else begin
            memwb_d_s.mo = 32'd0;
        end
    end

    pipe_mem_stage_mwreg u_mwreg (
        .clock  (clock),
        .resetn (resetn),
        .bubble (bubble_s),
        .d      (memwb_d_s),
        .q      (memwb_q_s)
    );

    assign wwreg  = memwb_q_s.wreg;
    assign wm2reg = memwb_q_s.m2reg;
    assign wmo    = memwb_q_s.mo;
    assign walu   = memwb_q_s.alu;
    assign wrn    = memwb_q_s.rn;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed self-checking bench for pipe_mem_stage; the timeout scenario runs when PIPE_MEM_TIMEOUT_EN is defined.
module tb_pipe_mem_stage;
    import pipe_mem_stage_pkg::*;

`ifdef PIPE_MEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] mAlu, mB;
    logic [4:0]  mrn;
    logic        mem_stall, mem_err, wwreg, wm2reg;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    pipe_mem_stage_if #(.ADDR_W(10)) dm_bus ();

    pipe_mem_stage #(.ADDR_W(10), .TIMEOUT(TB_TIMEOUT)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mwmem     (mwmem),
        .mAlu      (mAlu),
        .mB        (mB),
        .mrn       (mrn),
        .dm        (dm_bus.master),
        .mem_stall (mem_stall),
        .mem_err   (mem_err),
        .wwreg     (wwreg),
        .wm2reg    (wm2reg),
        .wmo       (wmo),
        .walu      (walu),
        .wrn       (wrn)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic wr, input logic ld, input logic st,
                          input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn);
        mwreg  = wr;
        mm2reg = ld;
        mwmem  = st;
        mAlu   = alu;
        mB     = b;
        mrn    = rn;
    endtask

    initial begin
        resetn = 1'b0;
        set_op(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 5'd0);
        dm_bus.dm_ack   = 1'b0;
        dm_bus.dm_rdata = 32'd0;
        #3;
        chk("rst_req_gated", 32'(dm_bus.dm_req), 32'd0);
        chk("rst_stall",     32'(mem_stall), 32'd0);
        chk("rst_err",       32'(mem_err), 32'd0);
        chk("rst_wwreg",     32'(wwreg), 32'd0);
        chk("rst_walu",      walu, 32'd0);
        chk("rst_wrn",       32'(wrn), 32'd0);
        set_op(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clock);
        resetn = 1'b1;
        step();

        // ALU op: no memory traffic, one-cycle latency
        set_op(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'd0, 5'd7);
        #1;
        chk("alu_req",   32'(dm_bus.dm_req), 32'd0);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        step();
        chk("alu_wwreg", 32'(wwreg), 32'd1);
        chk("alu_walu",  walu, 32'h0000_1234);
        chk("alu_wrn",   32'(wrn), 32'd7);

        // Zero-wait load
        set_op(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 5'd3);
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = 32'hDEAD_BEEF;
        #1;
        chk("zw_req",   32'(dm_bus.dm_req), 32'd1);
        chk("zw_we",    32'(dm_bus.dm_we), 32'd0);
        chk("zw_addr",  32'(dm_bus.dm_addr), 32'h10);
        chk("zw_stall", 32'(mem_stall), 32'd0);
        step();
        chk("zw_wmo",    wmo, 32'hDEAD_BEEF);
        chk("zw_wm2reg", 32'(wm2reg), 32'd1);
        chk("zw_wrn",    32'(wrn), 32'd3);

        // 3-wait store: three bubbles, data fields hold
        set_op(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0055, 5'd9);
        dm_bus.dm_ack   = 1'b0;
        dm_bus.dm_rdata = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_stall", 32'(mem_stall), 32'd1);
            chk("st_we",    32'(dm_bus.dm_we), 32'd1);
            chk("st_addr",  32'(dm_bus.dm_addr), 32'd2);
            chk("st_wdata", dm_bus.dm_wdata, 32'h0000_0055);
            step();
            chk("st_bub_wrn",   32'(wrn), 32'd0);
            chk("st_bub_wwreg", 32'(wwreg), 32'd0);
            chk("st_hold_walu", walu, 32'h0000_0040);
            chk("st_hold_wmo",  wmo, 32'hDEAD_BEEF);
        end
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = 32'h2222_2222;
        #1;
        chk("st_ack_stall", 32'(mem_stall), 32'd0);
        step();
        chk("st_done_wrn",  32'(wrn), 32'd9);
        chk("st_done_walu", walu, 32'h0000_0008);
        chk("st_done_wmo",  wmo, 32'd0);

        // Load and store both set: store wins
        set_op(1'b1, 1'b1, 1'b1, 32'h0000_000C, 32'h0000_0077, 5'd4);
        dm_bus.dm_rdata = 32'h3333_3333;
        #1;
        chk("both_we", 32'(dm_bus.dm_we), 32'd1);
        step();
        chk("both_wm2reg", 32'(wm2reg), 32'd0);
        chk("both_wmo",    wmo, 32'd0);
        chk("both_wrn",    32'(wrn), 32'd4);

        // Back-to-back loads, one wait each
        set_op(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'd0, 5'd10);
        dm_bus.dm_ack = 1'b0;
        #1;
        chk("b2b_a_stall", 32'(mem_stall), 32'd1);
        step();
        chk("b2b_a_bub", 32'(wwreg), 32'd0);
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = 32'hA0A0_A0A0;
        step();
        chk("b2b_a_wrn", 32'(wrn), 32'd10);
        chk("b2b_a_wmo", wmo, 32'hA0A0_A0A0);
        set_op(1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'd0, 5'd11);
        dm_bus.dm_ack = 1'b0;
        #1;
        chk("b2b_b_req",  32'(dm_bus.dm_req), 32'd1);
        chk("b2b_b_addr", 32'(dm_bus.dm_addr), 32'h41);
        step();
        chk("b2b_bub_wrn", 32'(wrn), 32'd0);
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = 32'hB0B0_B0B0;
        step();
        chk("b2b_b_wrn",  32'(wrn), 32'd11);
        chk("b2b_b_wmo",  wmo, 32'hB0B0_B0B0);
        chk("b2b_b_walu", walu, 32'h0000_0104);

        // Reset asserted while waiting
        set_op(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'd0, 5'd12);
        dm_bus.dm_ack = 1'b0;
        step();
        chk("rw_stall_pre", 32'(mem_stall), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rw_req",   32'(dm_bus.dm_req), 32'd0);
        chk("rw_stall", 32'(mem_stall), 32'd0);
        chk("rw_walu",  walu, 32'd0);
        chk("rw_wmo",   wmo, 32'd0);
        set_op(1'b1, 1'b0, 1'b0, 32'h0000_5678, 32'd0, 5'd31);
        @(negedge clock);
        resetn = 1'b1;
        step();
        chk("post_rst_wrn",  32'(wrn), 32'd31);
        chk("post_rst_walu", walu, 32'h0000_5678);

`ifdef PIPE_MEM_TIMEOUT_EN
        // Timeout: ack never arrives
        set_op(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 5'd12);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_stall", 32'(mem_stall), 32'd1);
            chk("to_err_pre", 32'(mem_err), 32'd0);
            step();
        end
        chk("to_err_set",  32'(mem_err), 32'd1);
        chk("to_err_stall", 32'(mem_stall), 32'd0);
        chk("to_err_req",  32'(dm_bus.dm_req), 32'd0);
        step();
        chk("to_kill_wwreg", 32'(wwreg), 32'd0);
        chk("to_kill_wrn",   32'(wrn), 32'd0);
        set_op(1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'd0, 5'd13);
        step();
        chk("to_next_wrn", 32'(wrn), 32'd13);
        chk("to_sticky",   32'(mem_err), 32'd1);
`else
        chk("no_to_err", 32'(mem_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
